// File: rtl/cpu_pkg.sv
// Shared decode definitions for the ID stage: opcodes, one-hot EX control bit indices, stall FSM states.
package cpu_pkg;

  localparam int CTRLW = 11;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h05;
  localparam logic [5:0] OP_OR   = 6'h06;
  localparam logic [5:0] OP_XOR  = 6'h07;
  localparam logic [5:0] OP_SLL  = 6'h03;
  localparam logic [5:0] OP_SRL  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h0B;
  localparam logic [5:0] OP_LI   = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam int CTRL_ADD  = 0;
  localparam int CTRL_SUB  = 1;
  localparam int CTRL_AND  = 2;
  localparam int CTRL_OR   = 3;
  localparam int CTRL_XOR  = 4;
  localparam int CTRL_SLL  = 5;
  localparam int CTRL_SRL  = 6;
  localparam int CTRL_ADDI = 7;
  localparam int CTRL_LI   = 8;
  localparam int CTRL_LW   = 9;
  localparam int CTRL_SW   = 10;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  typedef struct packed {
    logic [CTRLW-1:0] ctrl;
    logic             known;
    logic             uses_rt;
    logic             dest_rd;
    logic             dest_rt;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_ADD:  d.ctrl[CTRL_ADD]  = 1'b1;
      OP_SUB:  d.ctrl[CTRL_SUB]  = 1'b1;
      OP_AND:  d.ctrl[CTRL_AND]  = 1'b1;
      OP_OR:   d.ctrl[CTRL_OR]   = 1'b1;
      OP_XOR:  d.ctrl[CTRL_XOR]  = 1'b1;
      OP_SLL:  d.ctrl[CTRL_SLL]  = 1'b1;
      OP_SRL:  d.ctrl[CTRL_SRL]  = 1'b1;
      OP_ADDI: d.ctrl[CTRL_ADDI] = 1'b1;
      OP_LI:   d.ctrl[CTRL_LI]   = 1'b1;
      OP_LW:   d.ctrl[CTRL_LW]   = 1'b1;
      OP_SW:   d.ctrl[CTRL_SW]   = 1'b1;
      default: d.ctrl = '0;
    endcase
    d.known   = |d.ctrl;
    // R-type ops occupy the low contiguous bits and write rd; sw reads rt but writes nothing
    d.dest_rd = |d.ctrl[CTRL_SRL:CTRL_ADD];
    d.uses_rt = d.dest_rd | d.ctrl[CTRL_SW];
    d.dest_rt = d.ctrl[CTRL_ADDI] | d.ctrl[CTRL_LI] | d.ctrl[CTRL_LW];
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Register file, two async read ports and one sync write port; register 0 is hard-wired to zero.
module regfile_2r1w #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RA   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wr_en,
  input  logic [RA-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_dat,
  input  logic [RA-1:0]   i_rd0_addr,
  output logic [XLEN-1:0] o_rd0_dat,
  input  logic [RA-1:0]   i_rd1_addr,
  output logic [XLEN-1:0] o_rd1_dat
);

  logic [XLEN-1:0] r_mem [1:NREG-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_wr_en && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd0_dat = (i_rd0_addr == '0) ? '0 : r_mem[i_rd0_addr];
  assign o_rd1_dat = (i_rd1_addr == '0) ? '0 : r_mem[i_rd1_addr];

endmodule

// File: rtl/decode_stage_p.sv
// ID stage: decode, operand read with writeback bypass, load-use stall, flush; one-cycle registered ID/EX payload.
// Output register advances only when empty or EX takes it; FETCH is held off while EX stalls or a load-use hazard exists.
module decode_stage_p #(
  parameter  int XLEN     = 32,
  parameter  int NREG     = 32,
  parameter  int CTRLW    = cpu_pkg::CTRLW,
  parameter  int SIGN_EXT = 1,
  localparam int RA       = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  output logic             if_ready,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [RA-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [CTRLW-1:0] ex_ctrl,
  output logic [XLEN-1:0]  ex_rs_val,
  output logic [XLEN-1:0]  ex_rt_val,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA-1:0]    ex_dest,
  output logic             illegal
);
  import cpu_pkg::*;

  logic             r_valid;
  logic [CTRLW-1:0] r_ctrl;
  logic [XLEN-1:0]  r_rs_val;
  logic [XLEN-1:0]  r_rt_val;
  logic [XLEN-1:0]  r_imm;
  logic [RA-1:0]    r_dest;
  logic             r_illegal;
  state_t           r_state;
  state_t           w_state_nxt;

  logic [RA-1:0]    w_rs;
  logic [RA-1:0]    w_rt;
  logic [RA-1:0]    w_rd;
  dec_t             w_dec;
  logic [RA-1:0]    w_dest;
  logic [XLEN-1:0]  w_imm;
  logic [XLEN-1:0]  w_rf_rs;
  logic [XLEN-1:0]  w_rf_rt;
  logic [XLEN-1:0]  w_rs_val;
  logic [XLEN-1:0]  w_rt_val;
  logic             w_adv;
  logic             w_hazard;
  logic             w_take;

  assign w_rs  = RA'(if_instr[25:21]);
  assign w_rt  = RA'(if_instr[20:16]);
  assign w_rd  = RA'(if_instr[15:11]);
  assign w_dec = decode_op(if_instr[31:26]);

  assign w_dest = w_dec.dest_rd ? w_rd :
                  w_dec.dest_rt ? w_rt : '0;

  assign w_imm = (SIGN_EXT != 0) ? {{(XLEN-16){if_instr[15]}}, if_instr[15:0]}
                                 : {{(XLEN-16){1'b0}},         if_instr[15:0]};

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wb_en),
    .i_wr_addr  (wb_addr),
    .i_wr_dat   (wb_data),
    .i_rd0_addr (w_rs),
    .o_rd0_dat  (w_rf_rs),
    .i_rd1_addr (w_rt),
    .o_rd1_dat  (w_rf_rt)
  );

  // Same-cycle writeback wins over the stale array value; r0 is never bypassed
  assign w_rs_val = (wb_en && (wb_addr != '0) && (wb_addr == w_rs)) ? wb_data : w_rf_rs;
  assign w_rt_val = (wb_en && (wb_addr != '0) && (wb_addr == w_rt)) ? wb_data : w_rf_rt;

  assign w_adv    = !r_valid || ex_ready;
  assign w_hazard = if_valid && r_valid && r_ctrl[CTRL_LW] && (r_dest != '0) &&
                    ((r_dest == w_rs) || (w_dec.uses_rt && (r_dest == w_rt)));
  assign if_ready = rst_n && w_adv && !w_hazard;
  assign w_take   = if_valid && if_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (!flush && w_adv && w_hazard) w_state_nxt = STALL;
      STALL:   if (flush || w_adv)              w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_rs_val  <= '0;
      r_rt_val  <= '0;
      r_imm     <= '0;
      r_dest    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_take && !w_dec.known;
      if (flush || w_adv) begin
        // A flush squashes the slot even when EX is holding it off
        r_valid  <= w_take;
        r_ctrl   <= w_take ? w_dec.ctrl : '0;
        r_rs_val <= w_take ? w_rs_val   : '0;
        r_rt_val <= w_take ? w_rt_val   : '0;
        r_imm    <= w_take ? w_imm      : '0;
        r_dest   <= w_take ? w_dest     : '0;
      end
    end
  end

  assign ex_valid  = r_valid;
  assign ex_ctrl   = r_ctrl;
  assign ex_rs_val = r_rs_val;
  assign ex_rt_val = r_rt_val;
  assign ex_imm    = r_imm;
  assign ex_dest   = r_dest;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage_p.sv
// Scoreboard bench for decode_stage_p: sign- and zero-extending instances driven in lockstep.
module tb_decode_stage_p;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_valid, flush, wb_en, ex_ready;
  logic [31:0] if_instr, wb_data;
  logic [4:0]  wb_addr;

  logic        if_ready, ex_valid, illegal;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]  ex_dest;

  logic        u2_if_ready, u2_ex_valid, u2_illegal;
  logic [10:0] u2_ex_ctrl;
  logic [31:0] u2_ex_rs_val, u2_ex_rt_val, u2_ex_imm;
  logic [4:0]  u2_ex_dest;

  decode_stage_p #(.SIGN_EXT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_dest(ex_dest), .illegal(illegal)
  );

  decode_stage_p #(.SIGN_EXT(0)) u_dut_zx (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_ready(u2_if_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(u2_ex_valid), .ex_ctrl(u2_ex_ctrl), .ex_rs_val(u2_ex_rs_val), .ex_rt_val(u2_ex_rt_val),
    .ex_imm(u2_ex_imm), .ex_dest(u2_ex_dest), .illegal(u2_illegal)
  );

  typedef struct {
    logic [10:0] ctrl;
    logic [31:0] rs, rt, imm_s, imm_u;
    logic [4:0]  dest;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl_rf [32];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00: return 11'h001;
      6'h01: return 11'h002;
      6'h05: return 11'h004;
      6'h06: return 11'h008;
      6'h07: return 11'h010;
      6'h03: return 11'h020;
      6'h04: return 11'h040;
      6'h0B: return 11'h080;
      6'h02: return 11'h100;
      6'h23: return 11'h200;
      6'h2B: return 11'h400;
      default: return 11'h000;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && wb_addr == a) return wb_data;
    return mdl_rf[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs, rt, rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // One clock: score any EX transfer, predict any accepted instruction, then check the illegal pulse.
  task automatic cycle();
    exp_t        e, got;
    logic        acc, exp_ill;
    logic [10:0] c;
    @(negedge clk);
    if (ex_valid && ex_ready) begin
      chk("xfer_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        got = sb_q.pop_front();
        chk("ctrl",  32'(ex_ctrl),  32'(got.ctrl));
        chk("rs",    ex_rs_val,     got.rs);
        chk("rt",    ex_rt_val,     got.rt);
        chk("imm_s", ex_imm,        got.imm_s);
        chk("imm_u", u2_ex_imm,     got.imm_u);
        chk("dest",  32'(ex_dest),  32'(got.dest));
      end
    end
    if (flush && ex_valid && !ex_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    acc     = if_valid && if_ready && !flush;
    c       = m_ctrl(if_instr[31:26]);
    exp_ill = acc && (c == 11'h0);
    if (acc) begin
      e.ctrl  = c;
      e.rs    = m_read(if_instr[25:21]);
      e.rt    = m_read(if_instr[20:16]);
      e.imm_s = {{16{if_instr[15]}}, if_instr[15:0]};
      e.imm_u = {16'h0, if_instr[15:0]};
      e.dest  = (c[6:0] != 7'h0) ? if_instr[15:11] :
                (c[9:7] != 3'h0) ? if_instr[20:16] : 5'd0;
    end
    @(posedge clk);
    if (wb_en && wb_addr != 5'd0) mdl_rf[wb_addr] = wb_data;
    if (acc) sb_q.push_back(e);
    #1;
    chk("illegal", 32'(illegal), 32'(exp_ill));
  endtask

  task automatic peek_rdy(input string tag, input logic exp);
    #2;
    chk(tag, 32'(if_ready), 32'(exp));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_ctrl"},  32'(ex_ctrl),  32'd0);
    chk({tag, "_rs"},    ex_rs_val,     32'd0);
    chk({tag, "_rt"},    ex_rt_val,     32'd0);
    chk({tag, "_imm"},   ex_imm,        32'd0);
    chk({tag, "_dest"},  32'(ex_dest),  32'd0);
    chk({tag, "_ill"},   32'(illegal),  32'd0);
    chk({tag, "_rdy"},   32'(if_ready), 32'd0);
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    cycle();
    wb_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_rf[i] = 32'h0;
    rst_n = 1'b0; if_valid = 1'b1; if_instr = 32'h0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst0");
    rst_n = 1'b1; if_valid = 1'b0;

    // basic R-type
    wb(5'd1, 32'd2);
    wb(5'd2, 32'd1);
    if_valid = 1'b1; if_instr = rtype(6'h00, 5'd1, 5'd2, 5'd3);
    cycle();
    if_valid = 1'b0;
    cycle();

    // bypass, and r0 never bypassed
    if_valid = 1'b1; if_instr = rtype(6'h00, 5'd5, 5'd0, 5'd6);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
    cycle();
    if_instr = rtype(6'h01, 5'd0, 5'd5, 5'd7);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h55;
    cycle();
    wb_en = 1'b0; if_valid = 1'b0;
    cycle();

    // load-use on rs
    if_valid = 1'b1; if_instr = itype(6'h23, 5'd1, 5'd4, 16'h0);
    cycle();
    if_instr = rtype(6'h00, 5'd4, 5'd2, 5'd7);
    peek_rdy("hz_rdy", 1'b0);
    cycle();
    chk("hz_bubble", 32'(ex_valid), 32'd0);
    peek_rdy("hz_reissue_rdy", 1'b1);
    cycle();
    chk("hz_issue", 32'(ex_valid), 32'd1);

    // load-use on rt for sw
    if_instr = itype(6'h23, 5'd1, 5'd8, 16'h4);
    cycle();
    if_instr = itype(6'h2B, 5'd1, 5'd8, 16'h8);
    peek_rdy("hz_sw_rdy", 1'b0);
    cycle();
    chk("hz_sw_bubble", 32'(ex_valid), 32'd0);
    cycle();

    // no hazard: addi rt is a destination; lw to r0
    if_instr = itype(6'h23, 5'd1, 5'd9, 16'h0);
    cycle();
    if_instr = itype(6'h0B, 5'd1, 5'd9, 16'h1);
    peek_rdy("nohz_addi_rdy", 1'b1);
    cycle();
    if_instr = itype(6'h23, 5'd1, 5'd0, 16'h0);
    cycle();
    if_instr = rtype(6'h00, 5'd0, 5'd0, 5'd14);
    peek_rdy("nohz_r0_rdy", 1'b1);
    cycle();
    if_valid = 1'b0;
    cycle();

    // EX backpressure for 3 cycles, then flush of the held payload
    if_valid = 1'b1; if_instr = rtype(6'h01, 5'd1, 5'd2, 5'd8);
    cycle();
    ex_ready = 1'b0; if_instr = rtype(6'h05, 5'd1, 5'd2, 5'd9);
    for (int k = 0; k < 3; k++) begin
      peek_rdy("hold_rdy", 1'b0);
      cycle();
      chk("hold_valid", 32'(ex_valid), 32'd1);
      chk("hold_ctrl",  32'(ex_ctrl),  32'h002);
      chk("hold_rs",    ex_rs_val,     32'd2);
    end
    flush = 1'b1;
    cycle();
    chk("flush_hold_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; ex_ready = 1'b1;
    peek_rdy("post_flush_rdy", 1'b1);
    cycle();
    if_valid = 1'b0;
    cycle();

    // flush while stalled returns to normal issue
    if_valid = 1'b1; if_instr = itype(6'h23, 5'd1, 5'd10, 16'h0);
    cycle();
    if_instr = rtype(6'h00, 5'd10, 5'd0, 5'd11);
    peek_rdy("stall_rdy", 1'b0);
    cycle();
    flush = 1'b1;
    cycle();
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0; if_valid = 1'b0;
    cycle();
    if_valid = 1'b1;
    peek_rdy("after_stall_rdy", 1'b1);
    cycle();

    // immediates and illegal opcode, back to back
    if_instr = itype(6'h0B, 5'd1, 5'd12, 16'hFFFF);
    cycle();
    if_instr = itype(6'h02, 5'd0, 5'd13, 16'h8000);
    cycle();
    if_instr = {6'h3F, 26'h0123456};
    cycle();
    if_valid = 1'b0;
    cycle();
    cycle();

    // reset mid-traffic with a held payload
    if_valid = 1'b1; if_instr = rtype(6'h06, 5'd1, 5'd2, 5'd15);
    cycle();
    ex_ready = 1'b0; if_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst1");
    sb_q.delete();
    for (int i = 0; i < 32; i++) mdl_rf[i] = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1; ex_ready = 1'b1;
    if_valid = 1'b1; if_instr = rtype(6'h00, 5'd1, 5'd2, 5'd3);
    cycle();
    if_valid = 1'b0;
    repeat (3) cycle();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
